// File: rtl/cache_line_bus_ctrl_pkg.sv
// Shared AHB-Lite encodings and controller state type for the cache line bus controller.
package cache_line_bus_ctrl_pkg;

  localparam logic [1:0] AHB_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] AHB_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] AHB_HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] AHB_HBURST_SINGLE = 3'b000;
  localparam logic [2:0] AHB_HBURST_INCR4  = 3'b011;
  localparam logic [2:0] AHB_HBURST_INCR8  = 3'b101;
  localparam logic [2:0] AHB_HBURST_INCR16 = 3'b111;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_BURST,
    BUS_LASTDATA,
    BUS_DONE
  } bus_state_e;

  // Burst type for a line of the given number of beats; unsupported counts fall back to SINGLE.
  function automatic logic [2:0] beats_to_hburst(input int beats);
    case (beats)
      4:       return AHB_HBURST_INCR4;
      8:       return AHB_HBURST_INCR8;
      16:      return AHB_HBURST_INCR16;
      default: return AHB_HBURST_SINGLE;
    endcase
  endfunction

endpackage

// File: rtl/cache_line_bus_ctrl_counter.sv
// Beat counter: wraps to zero after TERM, flags the terminal beat.
module bus_beat_counter #(
  parameter int W    = 3,
  parameter int TERM = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         term_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign term_o = (cnt_q == W'(TERM));
  assign cnt_o  = cnt_q;

  // Clear dominates; an enabled terminal beat wraps back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = term_o ? '0 : cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cache_line_bus_ctrl.sv
// Turns a cache line fetch/writeback request into one AHB-Lite incrementing burst.
// LOGBWPL must be at least 1 (use 1 for single-beat lines).
module cache_line_bus_ctrl
  import cache_line_bus_ctrl_pkg::*;
#(
  parameter int PA_BITS = 32,
  parameter int AHBW    = 64,
  parameter int LINELEN = 512,
  parameter int LOGBWPL = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Stall,
  input  logic               Flush,
  input  logic [1:0]         CacheBusRW,
  input  logic [PA_BITS-1:0] CacheBusAdr,
  input  logic [AHBW-1:0]    CacheReadDataWord,
  output logic [LINELEN-1:0] FetchBuffer,
  output logic [LOGBWPL-1:0] BeatCount,
  output logic               SelBusBeat,
  output logic               CacheBusAck,
  output logic               BusCommitted,
  output logic [PA_BITS-1:0] HADDR,
  output logic [1:0]         HTRANS,
  output logic [2:0]         HBURST,
  output logic [2:0]         HSIZE,
  output logic               HWRITE,
  output logic [AHBW-1:0]    HWDATA,
  input  logic               HREADY,
  input  logic [AHBW-1:0]    HRDATA
);

  localparam int BEATS   = LINELEN / AHBW;
  localparam int BYTEOFF = $clog2(AHBW / 8);
  localparam int OFFSET  = $clog2(LINELEN / 8);

  bus_state_e state_q, state_d;
  logic       write_q, write_d;
  logic       dact_q;                 // a data phase is on the bus this cycle
  logic [1:0] htrans;
  logic       ack;
  logic       start;

  logic [LOGBWPL-1:0] adr_beat, data_beat;
  logic               adr_term, data_term;
  logic               adr_en, data_en;

  logic [BEATS-1:0][AHBW-1:0] fb_q;
  logic [BEATS-1:0]           slice_we;
  logic                       fetch_we;
  logic                       unused_adr;

  // Reset is folded in so an asserted reset never shows a NONSEQ from IDLE.
  assign start = (state_q == BUS_IDLE) & (|CacheBusRW) & ~Flush & ~reset;

  // Address beats advance on each accepted address phase; data beats on each completed data phase.
  assign adr_en  = HREADY & (start | (state_q == BUS_BURST));
  assign data_en = HREADY & dact_q;

  bus_beat_counter #(.W(LOGBWPL), .TERM(BEATS - 1)) u_adr_beat (
    .clk    (clk),
    .reset  (reset),
    .en_i   (adr_en),
    .clr_i  (state_q == BUS_DONE),
    .cnt_o  (adr_beat),
    .term_o (adr_term)
  );

  bus_beat_counter #(.W(LOGBWPL), .TERM(BEATS - 1)) u_data_beat (
    .clk    (clk),
    .reset  (reset),
    .en_i   (data_en),
    .clr_i  (state_q == BUS_IDLE),
    .cnt_o  (data_beat),
    .term_o (data_term)
  );

  // Next state, transfer type and completion pulse.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    htrans  = AHB_HTRANS_IDLE;
    ack     = 1'b0;
    unique case (state_q)
      BUS_IDLE: begin
        if (start) begin
          htrans  = AHB_HTRANS_NONSEQ;
          write_d = CacheBusRW[0];
          // A single-beat line whose only address is accepted goes straight to its data phase.
          state_d = ((BEATS == 1) && HREADY) ? BUS_LASTDATA : BUS_BURST;
        end
      end
      BUS_BURST: begin
        // Beat 0 only appears here if it was not accepted in IDLE; keep it NONSEQ.
        htrans = (adr_beat == '0) ? AHB_HTRANS_NONSEQ : AHB_HTRANS_SEQ;
        if (HREADY && adr_term) state_d = BUS_LASTDATA;
      end
      BUS_LASTDATA: begin
        if (HREADY && dact_q && data_term) begin
          ack     = 1'b1;
          state_d = BUS_DONE;
        end
      end
      BUS_DONE: begin
        if (!Stall) state_d = BUS_IDLE;
      end
      default: state_d = BUS_IDLE;
    endcase
  end

  // State, direction and data-phase tracking registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BUS_IDLE;
      write_q <= 1'b0;
      dact_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      if (HREADY) dact_q <= (htrans != AHB_HTRANS_IDLE);
    end
  end

  // One write enable per line slice, selected by the data beat.
  assign fetch_we = data_en & ~write_q;
  for (genvar b = 0; b < BEATS; b++) begin : g_slice
    assign slice_we[b] = fetch_we & (data_beat == LOGBWPL'(b));
  end

  // Fetch line assembly; untouched slices keep their contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb_q <= '0;
    end else begin
      for (int b = 0; b < BEATS; b++)
        if (slice_we[b]) fb_q[b] <= HRDATA;
    end
  end

  assign unused_adr   = ^CacheBusAdr[OFFSET-1:0];
  assign FetchBuffer  = fb_q;
  assign BeatCount    = data_beat;
  assign SelBusBeat   = write_q & (state_q != BUS_IDLE);
  assign CacheBusAck  = ack;
  assign BusCommitted = (state_q == BUS_BURST) | (state_q == BUS_LASTDATA);
  assign HADDR        = {CacheBusAdr[PA_BITS-1:OFFSET], {OFFSET{1'b0}}}
                      | (PA_BITS'(adr_beat) << BYTEOFF);
  assign HTRANS       = htrans;
  assign HBURST       = beats_to_hburst(BEATS);
  assign HSIZE        = 3'(BYTEOFF);
  assign HWRITE       = start ? CacheBusRW[0] : (write_q & (state_q != BUS_IDLE));
  assign HWDATA       = CacheReadDataWord;

endmodule
